// File: rtl/lcd_pkg.sv
// Shared LCD character constants, character type and the hex streamer state encoding.
package lcd_pkg;

  typedef logic [7:0] lcd_char_t;

  localparam lcd_char_t LCD_CHR_ZERO       = 8'h30;
  localparam lcd_char_t LCD_CHR_SPACE      = 8'h20;
  localparam lcd_char_t LCD_CGRAM_HEX_BASE = 8'h81;
  localparam lcd_char_t LCD_ASCII_A        = 8'h41;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } lcd_hex_state_e;

endpackage

// File: rtl/lcd_nibble_map.sv
// Combinational hex nibble to LCD character code; blank forces a space glyph.
module lcd_nibble_map
  import lcd_pkg::*;
#(
  parameter int ALPHA_MODE = 0
) (
  input  logic [3:0] nibble,
  input  logic       blank,
  output lcd_char_t  code
);

  always_comb begin
    code = LCD_CHR_ZERO;
    if (blank) begin
      code = LCD_CHR_SPACE;
    end else if (nibble < 4'd10) begin
      code = LCD_CHR_ZERO + {4'h0, nibble};
    end else if (ALPHA_MODE != 0) begin
      code = LCD_ASCII_A + {4'h0, nibble} - 8'd10;
    end else begin
      code = LCD_CGRAM_HEX_BASE + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/lcd_hex_streamer.sv
// Streams a NIBBLES-wide hex word as LCD character codes, MS nibble first.
// Optional leading-zero blanking is built when LCD_HEX_LZ_BLANK_EN is defined.
module lcd_hex_streamer
  import lcd_pkg::*;
#(
  parameter int NIBBLES    = 4,
  parameter int ALPHA_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_code,
  output logic                   out_last,
  output logic                   busy
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBBLES - 1);
  localparam logic LAST_AT_ACCEPT = (NIBBLES == 1);

  lcd_hex_state_e        state_q, state_nxt;
  logic [4*NIBBLES-1:0]  word_p0, word_nxt;
  logic [IDX_W-1:0]      idx_p0, idx_nxt, idx_dec;
  logic                  vld_p0, vld_nxt;
  logic                  last_p0, last_nxt;
  lcd_char_t             code_p0, code_nxt;
  lcd_char_t             map_code;
  logic [3:0]            nib_sel;
  logic                  blank_sel;
  logic [4*NIBBLES-1:0]  word_shift;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SEND);
  assign out_valid = vld_p0;
  assign out_last  = last_p0;
  assign out_code  = code_p0;

  // Next-nibble select: top of the incoming word at accept, else the next lower stored nibble.
  assign idx_dec    = idx_p0 - 1'b1;
  assign word_shift = word_p0 >> {idx_dec, 2'b00};
  assign nib_sel    = (state_q == IDLE) ? in_data[4*NIBBLES-1 -: 4] : word_shift[3:0];

`ifdef LCD_HEX_LZ_BLANK_EN
  logic blank_p0, blank_nxt;

  // Blanking runs while nibbles stay zero and never touches the LS digit.
  always_comb begin
    if (state_q == IDLE) begin
      blank_sel = (NIBBLES > 1) && (nib_sel == 4'h0);
    end else begin
      blank_sel = blank_p0 && (nib_sel == 4'h0) && (idx_dec != '0);
    end
    blank_nxt = blank_p0;
    if ((state_q == IDLE && in_valid) ||
        (state_q == SEND && out_ready && !last_p0)) begin
      blank_nxt = blank_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_p0 <= 1'b0;
    end else begin
      blank_p0 <= blank_nxt;
    end
  end
`else
  assign blank_sel = 1'b0;
`endif

  lcd_nibble_map #(
    .ALPHA_MODE (ALPHA_MODE)
  ) u_map (
    .nibble (nib_sel),
    .blank  (blank_sel),
    .code   (map_code)
  );

  always_comb begin
    state_nxt = state_q;
    word_nxt  = word_p0;
    idx_nxt   = idx_p0;
    vld_nxt   = vld_p0;
    last_nxt  = last_p0;
    code_nxt  = code_p0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_nxt  = in_data;
          idx_nxt   = IDX_TOP;
          vld_nxt   = 1'b1;
          last_nxt  = LAST_AT_ACCEPT;
          code_nxt  = map_code;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_p0) begin
            vld_nxt   = 1'b0;
            last_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            idx_nxt  = idx_dec;
            code_nxt = map_code;
            last_nxt = (idx_dec == '0);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Output stage: registered character, valid and last flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_p0 <= '0;
      idx_p0  <= '0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      code_p0 <= 8'h00;
    end else begin
      word_p0 <= word_nxt;
      idx_p0  <= idx_nxt;
      vld_p0  <= vld_nxt;
      last_p0 <= last_nxt;
      code_p0 <= code_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_hex_streamer.sv
// Directed bench for lcd_hex_streamer: 4-digit CGRAM, 4-digit ASCII and 1-digit instances.
module tb_lcd_hex_streamer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out_ready = 1'b1;

  logic        in_valid_m = 1'b0, in_ready_m, out_valid_m, out_last_m, busy_m;
  logic [15:0] in_data_m = '0;
  logic [7:0]  out_code_m;

  logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_last_a, busy_a;
  logic [15:0] in_data_a = '0;
  logic [7:0]  out_code_a;

  logic        in_valid_s = 1'b0, in_ready_s, out_valid_s, out_last_s, busy_s;
  logic [3:0]  in_data_s = '0;
  logic [7:0]  out_code_s;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lcd_hex_streamer #(.NIBBLES(4), .ALPHA_MODE(0)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m), .in_ready(in_ready_m),
    .in_data(in_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_code(out_code_m), .out_last(out_last_m), .busy(busy_m));

  lcd_hex_streamer #(.NIBBLES(4), .ALPHA_MODE(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_code(out_code_a), .out_last(out_last_a), .busy(busy_a));

  lcd_hex_streamer #(.NIBBLES(1), .ALPHA_MODE(0)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_data(in_data_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_code(out_code_s), .out_last(out_last_s), .busy(busy_s));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one word on instance m (alpha=0) or a (alpha=1), drain with out_ready high.
  task automatic run4(input string tag, input bit alpha, input logic [15:0] word,
                      input logic [31:0] exp);
    if (alpha) begin in_valid_a = 1'b1; in_data_a = word; end
    else       begin in_valid_m = 1'b1; in_data_m = word; end
    out_ready = 1'b1;
    step();
    in_valid_a = 1'b0;
    in_valid_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_vld"},  alpha ? out_valid_a : out_valid_m, 1);
      chk({tag, "_code"}, alpha ? out_code_a : out_code_m, exp[31-8*i -: 8]);
      chk({tag, "_last"}, alpha ? out_last_a : out_last_m, (i == 3) ? 1 : 0);
      chk({tag, "_rdy"},  alpha ? in_ready_a : in_ready_m, 0);
      step();
    end
    chk({tag, "_rdy_end"}, alpha ? in_ready_a : in_ready_m, 1);
    chk({tag, "_vld_end"}, alpha ? out_valid_a : out_valid_m, 0);
  endtask

  initial begin
    logic [7:0]  seen [4];
    logic [31:0] bexp;
    logic [7:0]  prev_code;
    bit          prev_stall;
    int          cnt;
    logic [7:0]  pat;

    #12;
    chk("rst_vld", out_valid_m, 0);
    chk("rst_code", out_code_m, 8'h00);
    chk("rst_last", out_last_m, 0);
    chk("rst_rdy", in_ready_m, 1);
    chk("rst_busy", busy_m, 0);
    chk("rst_vld_s", out_valid_s, 0);
    rst_n = 1'b1;
    step();

    run4("w1a3f", 1'b0, 16'h1A3F, 32'h31813386);
    run4("w1a3f_alpha", 1'b1, 16'h1A3F, 32'h31413346);

    // Stall pattern with in_valid held throughout.
    bexp = 32'h82858586;
    pat = 8'b10011010;
    in_valid_m = 1'b1; in_data_m = 16'hBEEF;
    step();
    in_data_m = 16'h1111;
    cnt = 0;
    prev_stall = 1'b0;
    prev_code = 8'h00;
    for (int k = 0; k < 20 && cnt < 4; k++) begin
      chk("beef_vld", out_valid_m, 1);
      chk("beef_rdy", in_ready_m, 0);
      if (prev_stall) chk("beef_hold", out_code_m, prev_code);
      out_ready = pat[7 - (k % 8)];
      if (out_ready) begin
        seen[cnt] = out_code_m;
        chk("beef_code", out_code_m, bexp[31-8*cnt -: 8]);
        cnt++;
      end
      prev_stall = !out_ready;
      prev_code = out_code_m;
      step();
    end
    in_valid_m = 1'b0;
    out_ready = 1'b1;
    chk("beef_count", cnt, 4);
    chk("beef_idle", in_ready_m, 1);
    chk("beef_no_accept", out_valid_m, 0);
    step();
    chk("beef_still_idle", out_valid_m, 0);

`ifdef LCD_HEX_LZ_BLANK_EN
    run4("w0070", 1'b0, 16'h0070, 32'h20203730);
    run4("w0000", 1'b0, 16'h0000, 32'h20202030);
`else
    run4("w0070", 1'b0, 16'h0070, 32'h30303730);
    run4("w0000", 1'b0, 16'h0000, 32'h30303030);
`endif

    // Asynchronous reset mid-word.
    in_valid_m = 1'b1; in_data_m = 16'h1234;
    step();
    in_valid_m = 1'b0;
    chk("r1234_c0", out_code_m, 8'h31);
    step();
    chk("r1234_c1", out_code_m, 8'h32);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", out_valid_m, 0);
    chk("arst_code", out_code_m, 8'h00);
    chk("arst_rdy", in_ready_m, 1);
    chk("arst_last", out_last_m, 0);
    #2 rst_n = 1'b1;
    step();
    run4("w5678", 1'b0, 16'h5678, 32'h35363738);

    // Single-nibble instance.
    in_valid_s = 1'b1; in_data_s = 4'hC;
    step();
    in_valid_s = 1'b0;
    chk("s_c_code", out_code_s, 8'h83);
    chk("s_c_last", out_last_s, 1);
    chk("s_c_vld", out_valid_s, 1);
    step();
    chk("s_c_done", out_valid_s, 0);
    in_valid_s = 1'b1; in_data_s = 4'h0;
    step();
    in_data_s = 4'h9;
    chk("s_0_code", out_code_s, 8'h30);
    chk("s_0_last", out_last_s, 1);
    step();
    chk("s_gap_vld", out_valid_s, 0);
    chk("s_gap_rdy", in_ready_s, 1);
    step();
    in_valid_s = 1'b0;
    chk("s_9_code", out_code_s, 8'h39);
    chk("s_9_vld", out_valid_s, 1);
    step();
    chk("s_9_done", out_valid_s, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_hex_streamer.md
# lcd_hex_streamer

Multi-digit successor to the single-nibble LCD character decoder. Accepts a `NIBBLES`-wide hex word over a valid/ready handshake and emits one 8-bit LCD character code per nibble, most-significant nibble first. Sits between datapath registers and the LCD write controller, feeding its character-write port. Supports a selectable A–F glyph mode and optional leading-zero blanking.

## Interface
- `NIBBLES`, default 4: hex digits per word; legal range 1–16.
- `ALPHA_MODE`, default 0: glyphs for digits 10–15.
  - 0: custom CGRAM codes 8'h81–8'h86.
  - 1: ASCII 'A'–'F', 8'h41–8'h46.
- `clk`  in  1: single clock; all state on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_data` holds a word to display.
- `in_ready`  out  1: block can accept a word.
- `in_data`  in  4*NIBBLES: hex word; bits [4*NIBBLES-1 -: 4] are sent first.
- `out_valid`  out  1: `out_code` holds a character.
- `out_ready`  in  1: downstream consumes the character.
- `out_code`  out  8: LCD character code.
- `out_last`  out  1: current character is the final (least-significant) digit of the word.
- `busy`  out  1: a word is in flight; inverse of `in_ready`.

## Operation
- **Digit map:**
  - 0–9 → 8'h30–8'h39.
  - 10–15 → 8'h81–8'h86 when `ALPHA_MODE`=0; 8'h41–8'h46 when `ALPHA_MODE`=1.
- **FSM, two states:**
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`:
    - latch `in_data` into the word register;
    - set digit index = NIBBLES-1;
    - load the code for the top nibble into `out_code`;
    - set `out_valid`=1;
    - set `out_last`=(NIBBLES==1);
    - go to SEND.
  - SEND: `in_ready`=0. `out_valid`, `out_code` and `out_last` hold stable until `out_valid`&&`out_ready`. On that handshake:
    - if `out_last`=1: clear `out_valid` and `out_last`, return to IDLE;
    - otherwise: decrement the index, load the next nibble's code, set `out_last` when the new index is 0.
- **Widths:**
  - Index register is max(1, $clog2(NIBBLES)) bits.
  - The index never wraps. The last handshake exits to IDLE and does not decrement.
- `in_data` changes while in SEND are ignored; the word is latched at accept.
- `in_valid` in SEND is not acknowledged. The upstream holds it until `in_ready` returns.
- Deasserting `out_ready` for any number of cycles stalls with outputs frozen.
- **Reset**, asserted at any time including mid-word:
  - state=IDLE; the in-flight word is discarded, not resumed;
  - `out_valid`=0, `out_last`=0, `out_code`=8'h00, `busy`=0, `in_ready`=1 (combinational from state);
  - index=0, word register=0.

## Timing
- Accept in cycle T → first character valid in cycle T+1. All outputs except `in_ready`/`busy` are registered.
- With `out_ready` held high, throughput is one character per cycle. A word occupies NIBBLES cycles in SEND.
- One IDLE cycle separates consecutive words. Sustained rate is NIBBLES characters per NIBBLES+1 cycles.
- No combinational path from `out_ready` or `in_valid` to any output.

## Configuration
- Macro: `LCD_HEX_LZ_BLANK_EN`.
- **Defined:** leading zero nibbles, scanning from the MS end, emit 8'h20 (space) instead of 8'h30.
  - Blanking stops at the first non-zero nibble.
  - The least-significant digit is never blanked.
  - Character count stays NIBBLES (fixed-width field).
  - The blank flag is a register set at accept and cleared at the first non-zero nibble.
- **Undefined:** every nibble is mapped literally; no blank-flag register exists.

## Structure
- Shared package `lcd_pkg`:
  - constants `LCD_CHR_ZERO`=8'h30, `LCD_CHR_SPACE`=8'h20, `LCD_CGRAM_HEX_BASE`=8'h81, `LCD_ASCII_A`=8'h41;
  - typedef `lcd_char_t` (8-bit logic);
  - enum `lcd_hex_state_e` {IDLE, SEND}.
- One sub-module `lcd_nibble_map`: combinational 4-bit → `lcd_char_t`, parameter `ALPHA_MODE`, input `blank` forcing `LCD_CHR_SPACE`. Instanced once on the next-nibble mux output.

## Test plan
- NIBBLES=4, ALPHA_MODE=0, `in_data`=16'h1A3F, `out_ready`=1 → 8'h31, 8'h81, 8'h33, 8'h86 on consecutive cycles; `out_last` only on 8'h86; `in_ready` high one cycle later.
- Same word, ALPHA_MODE=1 → 8'h31, 8'h41, 8'h33, 8'h46.
- 16'hBEEF with `out_ready` toggling 1,0,0,1,… → each code held stable while stalled; sequence 8'h82, 8'h85, 8'h85, 8'h86 with no loss or duplication; `in_valid` ignored throughout.
- 16'h0070: with `LCD_HEX_LZ_BLANK_EN` → 8'h20, 8'h20, 8'h37, 8'h30; without → 8'h30, 8'h30, 8'h37, 8'h30. 16'h0000 with macro → 8'h20, 8'h20, 8'h20, 8'h30.
- Drop `rst_n` after the second character of 16'h1234 → same cycle `out_valid`=0, `out_code`=8'h00, `in_ready`=1. Next accepted word 16'h5678 → 8'h35 first.
- NIBBLES=1, `in_data`=4'hC → single 8'h83 with `out_last`=1. Back-to-back words 4'h0 then 4'h9 → 8'h30, then 8'h39 two cycles later.
